// File: rtl/rgb_to_ycbcr.sv
// rgb_to_ycbcr: pipelined RGB -> YCbCr converter with a runtime-programmable 3x3 Q5.10
// matrix and per-channel integer offsets. Latency is 4 clocks at full throughput.
//
// Build option: define RGB_TO_YCBCR_ROUND_EN for round-half-up before the >>>10.
// Leave it undefined for a plain arithmetic shift (floor). Latency is the same in both builds.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   CI_A00..CI_A22        signed Q5.10 coefficients, row0->Y, row1->Cb, row2->Cr
//   CI_C0..CI_C2          signed integer offsets added to Y/Cb/Cr
//   r_i, g_i, b_i         unsigned input components
//   de_i, hs_i, vs_i      video syncs, delayed alongside the pixel
//   bypass_i              opaque sideband, delayed alongside the pixel
//   y_o, cb_o, cr_o       clamped unsigned output components
//   de_o, hs_o, vs_o      delayed syncs
//   bypass_o              delayed sideband
module rgb_to_ycbcr #(
    parameter int unsigned PIXEL_WIDTH  = 8,
    parameter int unsigned BYPASS_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             CI_A00,
    input  logic [15:0]             CI_A01,
    input  logic [15:0]             CI_A02,
    input  logic [15:0]             CI_A10,
    input  logic [15:0]             CI_A11,
    input  logic [15:0]             CI_A12,
    input  logic [15:0]             CI_A20,
    input  logic [15:0]             CI_A21,
    input  logic [15:0]             CI_A22,
    input  logic [15:0]             CI_C0,
    input  logic [15:0]             CI_C1,
    input  logic [15:0]             CI_C2,
    input  logic [PIXEL_WIDTH-1:0]  r_i,
    input  logic [PIXEL_WIDTH-1:0]  g_i,
    input  logic [PIXEL_WIDTH-1:0]  b_i,
    input  logic                    de_i,
    input  logic                    hs_i,
    input  logic                    vs_i,
    input  logic [BYPASS_WIDTH-1:0] bypass_i,
    output logic [PIXEL_WIDTH-1:0]  y_o,
    output logic [PIXEL_WIDTH-1:0]  cb_o,
    output logic [PIXEL_WIDTH-1:0]  cr_o,
    output logic                    de_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic [BYPASS_WIDTH-1:0] bypass_o
);

    localparam int unsigned ProdW = 17 + PIXEL_WIDTH;
    localparam int unsigned AccW  = ProdW + 2;
    localparam int unsigned ShW   = AccW - 10;
    localparam int unsigned ValW  = ((ShW > 16) ? ShW : 16) + 1;
    localparam int unsigned SideW = BYPASS_WIDTH + 3;

`ifdef RGB_TO_YCBCR_ROUND_EN
    localparam int RoundBias = 512;
`else
    localparam int RoundBias = 0;
`endif

    logic signed [15:0]          coef [3][3];
    logic signed [15:0]          off  [3];
    logic signed [PIXEL_WIDTH:0] pix  [3];

    logic signed [ProdW-1:0]     prod_d [3][3];
    logic signed [ProdW-1:0]     prod_q [3][3];
    logic signed [15:0]          off1_q [3];
    logic signed [15:0]          off2_q [3];
    logic signed [AccW-1:0]      acc_d  [3];
    logic signed [AccW-1:0]      acc_q  [3];
    logic signed [ValW-1:0]      val_d  [3];
    logic signed [ValW-1:0]      val_q  [3];
    logic [PIXEL_WIDTH-1:0]      out_d  [3];
    logic [PIXEL_WIDTH-1:0]      out_q  [3];
    // Tracks which stages hold real pixels, so reset bubbles reach the output as zeros
    // rather than as the bare offsets.
    logic                        v1_q, v2_q, v3_q;
    logic [SideW-1:0]            side_q [4];

    always_comb begin
        coef[0][0] = CI_A00;
        coef[0][1] = CI_A01;
        coef[0][2] = CI_A02;
        coef[1][0] = CI_A10;
        coef[1][1] = CI_A11;
        coef[1][2] = CI_A12;
        coef[2][0] = CI_A20;
        coef[2][1] = CI_A21;
        coef[2][2] = CI_A22;
        off[0]     = CI_C0;
        off[1]     = CI_C1;
        off[2]     = CI_C2;
        pix[0]     = {1'b0, r_i};
        pix[1]     = {1'b0, g_i};
        pix[2]     = {1'b0, b_i};
    end

    // S1: full-width signed products
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                prod_d[k][j] = ProdW'(coef[k][j]) * ProdW'(pix[j]);
            end
        end
    end

    // S2: per-channel sums
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            acc_d[k] = AccW'(prod_q[k][0]) + AccW'(prod_q[k][1]) + AccW'(prod_q[k][2]);
        end
    end

    // S3: optional rounding bias, arithmetic shift, offset
    always_comb begin
        logic signed [AccW-1:0] rnd;
        rnd = '0;
        for (int k = 0; k < 3; k++) begin
            rnd      = acc_q[k] + AccW'(RoundBias);
            val_d[k] = ValW'(rnd >>> 10) + ValW'(off2_q[k]);
        end
    end

    // S4: clamp to [0, 2**PIXEL_WIDTH-1]
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (!v3_q || val_q[k][ValW-1]) begin
                out_d[k] = '0;
            end else if (|val_q[k][ValW-2:PIXEL_WIDTH]) begin
                out_d[k] = {PIXEL_WIDTH{1'b1}};
            end else begin
                out_d[k] = val_q[k][PIXEL_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    prod_q[k][j] <= '0;
                end
                off1_q[k] <= '0;
                off2_q[k] <= '0;
                acc_q[k]  <= '0;
                val_q[k]  <= '0;
                out_q[k]  <= '0;
            end
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                side_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 3; j++) begin
                    prod_q[k][j] <= prod_d[k][j];
                end
                // Offsets travel with the pixel so a change only hits later pixels.
                off1_q[k] <= off[k];
                off2_q[k] <= off1_q[k];
                acc_q[k]  <= acc_d[k];
                val_q[k]  <= val_d[k];
                out_q[k]  <= out_d[k];
            end
            v1_q      <= 1'b1;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            side_q[0] <= {de_i, hs_i, vs_i, bypass_i};
            for (int i = 1; i < 4; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    assign y_o      = out_q[0];
    assign cb_o     = out_q[1];
    assign cr_o     = out_q[2];
    assign de_o     = side_q[3][SideW-1];
    assign hs_o     = side_q[3][SideW-2];
    assign vs_o     = side_q[3][SideW-3];
    assign bypass_o = side_q[3][BYPASS_WIDTH-1:0];

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Directed bench for rgb_to_ycbcr: reset state, primary colours, clamping, coefficient
// timing, a random stream against a behavioural model and a mid-stream reset.
module tb_rgb_to_ycbcr;

`ifdef RGB_TO_YCBCR_ROUND_EN
    localparam int RedCb = 85;
`else
    localparam int RedCb = 84;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a00, a01, a02, a10, a11, a12, a20, a21, a22, c0, c1, c2;
    logic [7:0]  r, g, b, byp;
    logic        de, hs, vs;
    logic [7:0]  y_o, cb_o, cr_o, bypass_o;
    logic        de_o, hs_o, vs_o;

    int checks = 0;
    int errors = 0;
    int ca [3][3];
    int cc [3];

    // Stream history, indexed by the negedge on which the pixel was driven
    logic [7:0]  hr [64];
    logic [7:0]  hg [64];
    logic [7:0]  hb [64];
    logic [10:0] hs_side [64];

    always #5 clk = ~clk;

    rgb_to_ycbcr dut (
        .clk      (clk),
        .rst      (rst),
        .CI_A00   (a00),
        .CI_A01   (a01),
        .CI_A02   (a02),
        .CI_A10   (a10),
        .CI_A11   (a11),
        .CI_A12   (a12),
        .CI_A20   (a20),
        .CI_A21   (a21),
        .CI_A22   (a22),
        .CI_C0    (c0),
        .CI_C1    (c1),
        .CI_C2    (c2),
        .r_i      (r),
        .g_i      (g),
        .b_i      (b),
        .de_i     (de),
        .hs_i     (hs),
        .vs_i     (vs),
        .bypass_i (byp),
        .y_o      (y_o),
        .cb_o     (cb_o),
        .cr_o     (cr_o),
        .de_o     (de_o),
        .hs_o     (hs_o),
        .vs_o     (vs_o),
        .bypass_o (bypass_o)
    );

    task automatic set_coeffs();
        a00 = 16'(ca[0][0]); a01 = 16'(ca[0][1]); a02 = 16'(ca[0][2]);
        a10 = 16'(ca[1][0]); a11 = 16'(ca[1][1]); a12 = 16'(ca[1][2]);
        a20 = 16'(ca[2][0]); a21 = 16'(ca[2][1]); a22 = 16'(ca[2][2]);
        c0  = 16'(cc[0]);    c1  = 16'(cc[1]);    c2  = 16'(cc[2]);
    endtask

    task automatic drive(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                         input logic dd, input logic hh, input logic vv,
                         input logic [7:0] pp);
        r = rr; g = gg; b = bb; de = dd; hs = hh; vs = vv; byp = pp;
    endtask

    // Drives one pixel, idles, and returns on the negedge where that pixel is at the output.
    task automatic send_pixel(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                              input logic [7:0] pp);
        @(negedge clk);
        drive(rr, gg, bb, 1'b1, 1'b1, 1'b0, pp);
        @(negedge clk);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) @(negedge clk);
    endtask

    // Behavioural reference: floor or round-half-up, then offset, then clamp.
    function automatic logic [7:0] ref_ch(input int k, input int rr, input int gg, input int bb);
        int acc;
        acc = ca[k][0] * rr + ca[k][1] * gg + ca[k][2] * bb;
`ifdef RGB_TO_YCBCR_ROUND_EN
        acc = acc + 512;
`endif
        acc = (acc >>> 10) + cc[k];
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
        return 8'(acc);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(8'd255, 8'd255, 8'd255, 1'b1, 1'b1, 1'b1, 8'hA5);
        repeat (3) @(negedge clk);
        checks++;
        if ({y_o, cb_o, cr_o} !== 24'h0) begin
            errors++;
            $display("FAIL reset_pix: got %h %h %h want 00 00 00", y_o, cb_o, cr_o);
        end
        checks++;
        if ({de_o, hs_o, vs_o, bypass_o} !== 11'h0) begin
            errors++;
            $display("FAIL reset_side: got %b%b%b %h want 000 00", de_o, hs_o, vs_o, bypass_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({y_o, cb_o, cr_o, de_o, hs_o, vs_o, bypass_o} !== 35'h0) begin
            errors++;
            $display("FAIL reset_after: got %h %h %h %b%b%b %h want all zero",
                     y_o, cb_o, cr_o, de_o, hs_o, vs_o, bypass_o);
        end
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_white();
        @(negedge clk);
        drive(8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 1'b1, 8'h3C);
        @(negedge clk);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (de_o !== 1'b0) begin
            errors++;
            $display("FAIL white_early: de_o got %b want 0 one clk before latency", de_o);
        end
        @(negedge clk);
        checks++;
        if ({y_o, cb_o, cr_o} !== {8'd255, 8'd128, 8'd128}) begin
            errors++;
            $display("FAIL white: got %0d %0d %0d want 255 128 128", y_o, cb_o, cr_o);
        end
        checks++;
        if ({de_o, hs_o, vs_o, bypass_o} !== {3'b101, 8'h3C}) begin
            errors++;
            $display("FAIL white_side: got %b%b%b %h want 101 3c", de_o, hs_o, vs_o, bypass_o);
        end
        @(negedge clk);
        checks++;
        if ({de_o, y_o} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL white_next: got de %b y %0d want de 0 y 0", de_o, y_o);
        end
    endtask

    task automatic test_black();
        send_pixel(8'd0, 8'd0, 8'd0, 8'h11);
        checks++;
        if ({y_o, cb_o, cr_o} !== {8'd0, 8'd128, 8'd128}) begin
            errors++;
            $display("FAIL black: got %0d %0d %0d want 0 128 128", y_o, cb_o, cr_o);
        end
    endtask

    task automatic test_red();
        send_pixel(8'd255, 8'd0, 8'd0, 8'h22);
        checks++;
        if ({y_o, cb_o, cr_o} !== {8'd76, 8'(RedCb), 8'd255}) begin
            errors++;
            $display("FAIL red: got %0d %0d %0d want 76 %0d 255", y_o, cb_o, cr_o, RedCb);
        end
    endtask

    task automatic test_blue_clamp();
        send_pixel(8'd0, 8'd0, 8'd255, 8'h33);
        checks++;
        if ({y_o, cb_o, cr_o} !== {8'd29, 8'd255, 8'd107}) begin
            errors++;
            $display("FAIL blue: got %0d %0d %0d want 29 255 107", y_o, cb_o, cr_o);
        end
        // Red with C1=128, then red with C1=0 on the next clk: only the second sees the change.
        @(negedge clk);
        drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h44);
        @(negedge clk);
        cc[1] = 0;
        set_coeffs();
        drive(8'd255, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h55);
        @(negedge clk);
        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (cb_o !== 8'(RedCb)) begin
            errors++;
            $display("FAIL coeff_inflight: cb got %0d want %0d", cb_o, RedCb);
        end
        @(negedge clk);
        checks++;
        if ({y_o, cb_o, bypass_o} !== {8'd76, 8'd0, 8'h55}) begin
            errors++;
            $display("FAIL cb_clamp0: got y %0d cb %0d byp %h want 76 0 55", y_o, cb_o, bypass_o);
        end
        cc[1] = 128;
        set_coeffs();
    endtask

    // Random stream; rst_at < 0 disables the mid-stream reset.
    task automatic run_stream(input string tag, input int n, input int rst_at);
        logic [7:0] ey, ecb, ecr;
        logic [10:0] eside;
        for (int t = 0; t < n + 4; t++) begin
            @(negedge clk);
            if (t >= 4) begin
                if (rst_at >= 0 && t > rst_at && t <= rst_at + 4) begin
                    ey = 8'd0; ecb = 8'd0; ecr = 8'd0; eside = 11'd0;
                end else begin
                    ey    = ref_ch(0, int'(hr[t-4]), int'(hg[t-4]), int'(hb[t-4]));
                    ecb   = ref_ch(1, int'(hr[t-4]), int'(hg[t-4]), int'(hb[t-4]));
                    ecr   = ref_ch(2, int'(hr[t-4]), int'(hg[t-4]), int'(hb[t-4]));
                    eside = hs_side[t-4];
                end
                checks++;
                if ({y_o, cb_o, cr_o} !== {ey, ecb, ecr}) begin
                    errors++;
                    $display("FAIL %s_pix t=%0d: got %0d %0d %0d want %0d %0d %0d",
                             tag, t, y_o, cb_o, cr_o, ey, ecb, ecr);
                end
                checks++;
                if ({de_o, hs_o, vs_o, bypass_o} !== eside) begin
                    errors++;
                    $display("FAIL %s_side t=%0d: got %b%b%b %h want %b %h", tag, t,
                             de_o, hs_o, vs_o, bypass_o, eside[10:8], eside[7:0]);
                end
            end
            if (t < n) begin
                hr[t] = (t % 7 == 0) ? 8'd255 : 8'($urandom_range(0, 255));
                hg[t] = (t % 5 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                hb[t] = 8'($urandom_range(0, 255));
                hs_side[t] = 11'($urandom_range(0, 2047));
                drive(hr[t], hg[t], hb[t], hs_side[t][10], hs_side[t][9], hs_side[t][8],
                      hs_side[t][7:0]);
            end else begin
                drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
            end
            rst = (t == rst_at);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        run_stream("stream", 40, -1);
    endtask

    task automatic test_reset_mid();
        run_stream("rstmid", 24, 10);
    endtask

    initial begin
        ca[0][0] = 306;  ca[0][1] = 601;  ca[0][2] = 117;
        ca[1][0] = -173; ca[1][1] = -339; ca[1][2] = 512;
        ca[2][0] = 512;  ca[2][1] = -429; ca[2][2] = -83;
        cc[0] = 0; cc[1] = 128; cc[2] = 128;
        set_coeffs();
        test_reset();
        test_white();
        test_black();
        test_red();
        test_blue_clamp();
        test_stream();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
